// File: rtl/fsm_trace_pkg.sv
// fsm_trace_pkg: state encodings, trace entry layout {state, out, gap} and entry width helper.
package fsm_trace_pkg;
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_e;
    localparam int GAP_LSB = 0;
    function automatic int out_pos(input int ts_w);
        return ts_w;
    endfunction
    function automatic int state_lsb(input int ts_w);
        return ts_w + 1;
    endfunction
    function automatic int entry_w(input int ts_w);
        return ts_w + 3;
    endfunction
endpackage

// File: rtl/fsm_trace_capture_if.sv
// fsm_trace_capture_if: valid/ready read port carrying trace entries out of the capture block.
interface fsm_trace_capture_if
    import fsm_trace_pkg::*;
#(
    parameter int TS_W = 16
);
    logic                      rd_valid;
    logic                      rd_ready;
    logic [entry_w(TS_W)-1:0]  rd_data;
    modport master(output rd_valid, output rd_data, input rd_ready);
    modport slave(input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: pointer + count synchronous FIFO; a write when full is taken only alongside a read.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_rd, do_wr;
    always_comb begin
        rd_valid_o = cnt_q != '0;
        full_o     = cnt_q == (AW+1)'(DEPTH);
        do_rd      = rd_i && rd_valid_o;
        do_wr      = wr_i && (!full_o || do_rd);
        rd_data_o  = mem_q[rptr_q];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wptr_q] <= wr_data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/fsm_trace_capture.sv
// fsm_trace_capture: records every change of the FSM {state, out} pair with its cycle gap into a FIFO.
// Define FSM_TRACE_SEQ_CHECK_EN to build the sticky illegal-transition checker behind seq_err.
module fsm_trace_capture
    import fsm_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           state_in,
    input  logic                 out_in,
    input  logic                 clr,
    fsm_trace_capture_if.master  rd,
    output logic                 overflow,
    output logic [CNT_W-1:0]     event_count,
    output logic                 seq_err
);
    localparam int EW     = entry_w(TS_W);
    localparam int ST_LSB = state_lsb(TS_W);
    localparam int OUT_B  = out_pos(TS_W);
    logic [2:0]       prev_q;
    logic [TS_W-1:0]  gap_q, gap_d, gap_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ev, push, pop, full;
    logic [EW-1:0]    entry;
    always_comb begin
        ev      = {state_in, out_in} != prev_q;
        gap_inc = &gap_q ? gap_q : gap_q + 1'b1;
        gap_d   = (clr || ev) ? '0 : gap_inc;
        cnt_d   = clr ? '0 : cnt_q + CNT_W'(ev);
        push    = ev && !clr;
        pop     = rd.rd_valid && rd.rd_ready;
        ovf_d   = !clr && (ovf_q || (push && full && !pop));
        entry   = '0;
        entry[ST_LSB +: 2]     = state_in;
        entry[OUT_B]           = out_in;
        entry[GAP_LSB +: TS_W] = gap_inc;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            gap_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= {state_in, out_in};
            gap_q  <= gap_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end
    assign overflow    = ovf_q;
    assign event_count = cnt_q;
    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (clr),
        .wr_i      (push),
        .wr_data_i (entry),
        .rd_i      (rd.rd_ready),
        .rd_valid_o(rd.rd_valid),
        .rd_data_o (rd.rd_data),
        .full_o    (full)
    );
`ifdef FSM_TRACE_SEQ_CHECK_EN
    // Legal state moves are "stay" or "advance by one, wrapping 3 -> 0".
    logic   seq_q, seq_d;
    state_e exp_s;
    always_comb begin
        exp_s = state_e'(prev_q[2:1] + 2'd1);
        seq_d = !clr && (seq_q || (ev && state_in != prev_q[2:1] && state_in != exp_s));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) seq_q <= 1'b0;
        else     seq_q <= seq_d;
    end
    assign seq_err = seq_q;
`else
    assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_trace_capture.sv
// tb_fsm_trace_capture: directed scenario tasks with hand-computed entries for fsm_trace_capture.
module tb_fsm_trace_capture;
    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int CNT_W = 16;
    localparam int EW    = 3 + TS_W;
`ifdef FSM_TRACE_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic [1:0]       state_in = 2'b00;
    logic             out_in = 1'b0;
    logic             overflow, seq_err;
    logic [CNT_W-1:0] event_count;
    int               checks = 0;
    int               errors = 0;

    fsm_trace_capture_if #(.TS_W(TS_W)) rd ();

    fsm_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .state_in   (state_in),
        .out_in     (out_in),
        .clr        (clr),
        .rd         (rd),
        .overflow   (overflow),
        .event_count(event_count),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] v);
        {state_in, out_in} = v;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clr = 1'b0;
        rd.rd_ready = 1'b0;
        set_in(3'b000);
        step(1);
        rst = 1'b0;
    endtask

    task automatic pop(output logic v, output logic [EW-1:0] d);
        v = rd.rd_valid;
        d = rd.rd_data;
        rd.rd_ready = 1'b1;
        step(1);
        rd.rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd.rd_valid); end
        checks++; if (rd.rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd.rd_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (event_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", event_count); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq: got %b expected 0", seq_err); end
        step(3);
        checks++; if (event_count !== '0 || rd.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_no_event: got count %0d valid %b expected 0 0", event_count, rd.rd_valid); end
    endtask

    task automatic test_basic;
        logic v;
        logic [EW-1:0] d;
        do_reset();
        step(2);
        set_in(3'b010);
        step(1);
        checks++; if (rd.rd_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", rd.rd_valid); end
        step(3);
        set_in(3'b100);
        step(1);
        checks++; if (event_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", event_count); end
        pop(v, d);
        checks++; if (v !== 1'b1 || d !== 7'b010_0011) begin errors++; $display("FAIL basic_entry0: got v=%b d=%b expected v=1 d=0100011", v, d); end
        pop(v, d);
        checks++; if (v !== 1'b1 || d !== 7'b100_0100) begin errors++; $display("FAIL basic_entry1: got v=%b d=%b expected v=1 d=1000100", v, d); end
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", rd.rd_valid); end
    endtask

    task automatic test_overflow;
        logic v;
        logic [EW-1:0] d;
        logic [EW-1:0] e;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            set_in(i[2:0]);
            step(1);
            if (i == 8) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (event_count !== 16'd9) begin errors++; $display("FAIL ovf_count: got %0d expected 9", event_count); end
        for (int i = 1; i <= 8; i++) begin
            e = {i[2:0], 4'd1};
            pop(v, d);
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL ovf_entry%0d: got v=%b d=%b expected v=1 d=%b", i, v, d, e); end
        end
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", rd.rd_valid); end
    endtask

    task automatic test_full_pushpop;
        logic v;
        logic [EW-1:0] d;
        logic [EW-1:0] e;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            set_in(i[2:0]);
            step(1);
        end
        set_in(3'b001);
        rd.rd_ready = 1'b1;
        step(1);
        rd.rd_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf: got %b expected 0", overflow); end
        checks++; if (event_count !== 16'd9) begin errors++; $display("FAIL full_pp_count: got %0d expected 9", event_count); end
        for (int i = 2; i <= 9; i++) begin
            e = {i[2:0], 4'd1};
            pop(v, d);
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL full_pp_entry%0d: got v=%b d=%b expected v=1 d=%b", i, v, d, e); end
        end
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL full_pp_drained: got %b expected 0", rd.rd_valid); end
    endtask

    task automatic test_gap_sat;
        do_reset();
        step(40);
        set_in(3'b010);
        step(1);
        checks++; if (rd.rd_valid !== 1'b1 || rd.rd_data !== 7'b010_1111) begin errors++; $display("FAIL gap_sat: got v=%b d=%b expected v=1 d=0101111", rd.rd_valid, rd.rd_data); end
    endtask

    task automatic test_clr_and_reset;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            set_in(i[2:0]);
            step(1);
        end
        clr = 1'b1;
        set_in(3'b110);
        step(1);
        clr = 1'b0;
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL clr_empty: got %b expected 0", rd.rd_valid); end
        checks++; if (event_count !== '0) begin errors++; $display("FAIL clr_count: got %0d expected 0", event_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", overflow); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL clr_seq: got %b expected 0", seq_err); end
        step(1);
        checks++; if (event_count !== '0 || rd.rd_valid !== 1'b0) begin errors++; $display("FAIL clr_prev_updated: got count %0d valid %b expected 0 0", event_count, rd.rd_valid); end
        step(2);
        set_in(3'b111);
        step(1);
        checks++; if (rd.rd_valid !== 1'b1 || rd.rd_data !== 7'b111_0100) begin errors++; $display("FAIL clr_gap: got v=%b d=%b expected v=1 d=1110100", rd.rd_valid, rd.rd_data); end
        checks++; if (event_count !== 16'd1) begin errors++; $display("FAIL clr_recount: got %0d expected 1", event_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rd.rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", rd.rd_valid); end
        checks++; if (event_count !== '0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", event_count); end
        do_reset();
        step(2);
        set_in(3'b010);
        step(1);
        checks++; if (rd.rd_valid !== 1'b1 || rd.rd_data !== 7'b010_0011) begin errors++; $display("FAIL post_reset_gap: got v=%b d=%b expected v=1 d=0100011", rd.rd_valid, rd.rd_data); end
    endtask

    task automatic test_seq;
        do_reset();
        set_in(3'b001);
        step(1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_out_only: got %b expected 0", seq_err); end
        set_in(3'b011);
        step(1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_legal_step: got %b expected 0", seq_err); end
        set_in(3'b111);
        step(1);
        checks++; if (seq_err !== SEQ_ON) begin errors++; $display("FAIL seq_skip: got %b expected %b", seq_err, SEQ_ON); end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clr: got %b expected 0", seq_err); end
        set_in(3'b000);
        step(1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_wrap: got %b expected 0", seq_err); end
        set_in(3'b100);
        step(1);
        checks++; if (seq_err !== SEQ_ON) begin errors++; $display("FAIL seq_00_to_10: got %b expected %b", seq_err, SEQ_ON); end
        set_in(3'b101);
        step(1);
        checks++; if (seq_err !== SEQ_ON) begin errors++; $display("FAIL seq_sticky: got %b expected %b", seq_err, SEQ_ON); end
    endtask

    initial begin
        rd.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_gap_sat();
        test_clr_and_reset();
        test_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsm_trace_capture.md
# fsm_trace_capture

Downstream observer for the 2-bit Moore FSM. It samples the FSM's `state_out`/`out` pair every clock and records every change as an event. Each event is stored with the number of cycles since the previous event. Events are buffered in a small FIFO and drained by a valid/ready reader, such as a debug UART or a bench scoreboard.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; must be a power of 2, ≥ 2.
- `TS_W`, default 16: width of the gap timestamp.
- `CNT_W`, default 16: width of the event counter.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `state_in`, in, 2: FSM `state_out`; same clock domain, no synchroniser.
- `out_in`, in, 1: FSM `out`.
- `clr`, in, 1: synchronous flush of FIFO, counters and sticky flags.
- `rd_ready`, in, 1: consumer accepts the head entry.
- `rd_valid`, out, 1: FIFO non-empty.
- `rd_data`, out, 3+TS_W: head entry, `{state[1:0], out, gap[TS_W-1:0]}`.
- `overflow`, out, 1: sticky; an event was dropped because the FIFO was full.
- `event_count`, out, CNT_W: total events detected, including dropped ones.
- `seq_err`, out, 1: sticky illegal-transition flag (see Configuration).

## Operation
- `prev` register holds the previous `{state_in, out_in}`. Its reset value is `{2'b00, 1'b0}`. It is updated every edge.
- Event: asserted at an edge when `{state_in, out_in} != prev`.
- `gap_cnt`:
  - Resets to 0.
  - Each edge: on an event it is loaded with 0; otherwise it becomes `min(gap_cnt+1, 2^TS_W-1)`.
  - Recorded gap = `min(gap_cnt+1, 2^TS_W-1)`, i.e. the number of edges since the previous event edge, or since reset release.
- Push: on an event, the entry `{state_in, out_in, gap}` is written at that edge.
- Pop: when `rd_valid && rd_ready` at an edge.
- Full FIFO:
  - An event with no simultaneous pop is dropped and `overflow` is set.
  - An event with a simultaneous pop is accepted and the occupancy stays at DEPTH.
- Empty FIFO: a push has no bypass. The entry appears on the next cycle.
- `event_count`: increments on every event and wraps modulo 2^CNT_W.
- `clr` has priority over an event on the same edge:
  - Empties the FIFO.
  - Zeroes `gap_cnt` and `event_count`.
  - Clears `overflow` and `seq_err`.
  - Still updates `prev`.
- `rd_data` is undefined-but-stable when `rd_valid=0`. It holds steady while `rd_valid && !rd_ready`.

## Timing
- Reset values: `rd_valid=0`, `rd_data=0`, `overflow=0`, `event_count=0`, `seq_err=0`. Reset is asynchronous: `rd_valid` drops immediately when `rst` asserts.
- Latency: an input change present before edge k produces an entry visible with `rd_valid=1` after edge k (1 cycle).
- Throughput: one push and one pop per cycle.
- Flags update at the same edge as the event that causes them.
- Reset mid-operation discards all entries. The first post-reset event reports a gap counted from reset release.

## Configuration
- `FSM_TRACE_SEQ_CHECK_EN` defined:
  - Any event where the state changes to something other than `prev_state+1 mod 4` sets `seq_err`.
  - Events where only `out` changes are legal.
  - The entry is still recorded.
- Macro undefined: `seq_err` is tied to 0 and no checker logic is built.

## Structure
- Package `fsm_trace_pkg` holds:
  - State encodings `S0`–`S3` (`2'b00`–`2'b11`).
  - The entry field offsets.
  - The function `entry_w(TS_W)` (returns 3+TS_W).
- Sub-module `trace_fifo`: a synchronous FIFO parameterised by width and depth. It uses a pointer + count scheme and accepts a write when full only if a read happens on the same edge.
- Top level holds the change detector, gap counter, event counter, flags and sequence checker.

## Test plan
- **Basic recording:** reset; drive state 00→01 at edge 3, then 01→10 at edge 7; hold `rd_ready=0`. Expect 2 entries: `{01,0,gap=3}` and `{10,0,gap=4}`. Expect `event_count=2`.
- **Overflow with DEPTH=8:** produce 9 changes with `rd_ready=0`. Expect `overflow=1` after the 9th change, 8 entries read back in order, and `event_count=9`.
- **Push and pop while full:** fill to 8; on the same edge pop and create an event. Expect `overflow=0` and occupancy still 8, with the new entry last.
- **Gap saturation with TS_W=4:** hold the input for 40 cycles, then change. Expect `gap=15`.
- **clr priority and reset:** assert `clr` on the same edge as an event. Expect an empty FIFO, `event_count=0` and flags clear. Assert `rst` mid-stream: expect `rd_valid` to drop without waiting for a clock edge.
- **Sequence check (macro on):** drive 00→10. Expect `seq_err=1`. Drive an `out`-only toggle: expect no additional error. With the macro off, `seq_err` stays 0.
